// File: rtl/kv_filter_table_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : kv_filter_table_if
// Brief    : Request/reply bundle between the RX parser and the flow table.
// Revision : 1.0 - initial release
// ============================================================================
interface kv_filter_table_if #(
    parameter int KEY_SIZE = 96
);
    logic [KEY_SIZE-1:0] in_key;
    logic [3:0]          in_flag;
    logic                in_valid;
    logic                out_valid;
    logic [3:0]          out_flag;
    logic                init_done;
    logic [7:0]          debug;

    modport master (
        output in_key, in_flag, in_valid,
        input  out_valid, out_flag, init_done, debug
    );

    modport slave (
        input  in_key, in_flag, in_valid,
        output out_valid, out_flag, init_done, debug
    );
endinterface
`default_nettype wire

// File: rtl/kv_filter_table.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : kv_filter_table
// Brief    : Direct-mapped flow-state table, 3-stage pipelined SUSPECT/ARREST
//            lookup-update with a power-up clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module kv_filter_table #(
    parameter int KEY_SIZE   = 96,
    parameter int INDEX_BITS = 10
) (
    input wire               clk156,
    input wire               eth_rst,
    kv_filter_table_if.slave bus
);

    localparam int c_DEPTH    = 1 << INDEX_BITS;
    localparam int c_ENTRY_W  = KEY_SIZE + 3;
    localparam int c_N_SLICES = (KEY_SIZE + INDEX_BITS - 1) / INDEX_BITS;
    localparam int c_PAD_W    = c_N_SLICES * INDEX_BITS;

    localparam logic [1:0]            c_SUSPECT    = 2'b01;
    localparam logic [1:0]            c_ARREST     = 2'b10;
    localparam logic [INDEX_BITS-1:0] c_SWEEP_LAST = '1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [INDEX_BITS-1:0] r_sweep;
    logic                  r_init_done;
    logic                  r_drop_seen;
    logic [5:0]            r_arrest_cnt;

    logic                  r_p1_valid;
    logic [KEY_SIZE-1:0]   r_p1_key;
    logic [1:0]            r_p1_op;
    logic [INDEX_BITS-1:0] r_p1_idx;

    logic                  r_p2_valid;
    logic [KEY_SIZE-1:0]   r_p2_key;
    logic [1:0]            r_p2_op;
    logic [INDEX_BITS-1:0] r_p2_idx;
    logic                  r_p2_fwd;
    logic [c_ENTRY_W-1:0]  r_p2_fwd_data;
    logic [c_ENTRY_W-1:0]  r_rd_data;

    logic                  r_out_valid;
    logic [3:0]            r_out_flag;

    logic [c_ENTRY_W-1:0]  r_mem [c_DEPTH];

    logic [c_PAD_W-1:0]    w_key_pad;
    logic [INDEX_BITS-1:0] w_in_idx;
    logic                  w_accept;
    logic [c_ENTRY_W-1:0]  w_entry;
    logic                  w_hit;
    logic                  w_p2_we;
    logic [1:0]            w_p2_new_status;
    logic [c_ENTRY_W-1:0]  w_p2_wdata;
    logic [1:0]            w_p2_status;
    logic                  w_p2_hit_rep;
    logic                  w_mem_we;
    logic [INDEX_BITS-1:0] w_mem_waddr;
    logic [c_ENTRY_W-1:0]  w_mem_wdata;

    // XOR-fold of the key; bits above KEY_SIZE in the last slice read as zero.
    always_comb begin
        w_key_pad                 = '0;
        w_key_pad[KEY_SIZE-1:0]   = bus.in_key;
        w_in_idx                  = '0;
        for (int i = 0; i < c_N_SLICES; i++) begin
            w_in_idx = w_in_idx ^ w_key_pad[i*INDEX_BITS +: INDEX_BITS];
        end
    end

    assign w_accept = bus.in_valid && bus.in_flag[0] && r_init_done;

    // Init sweep FSM; init_done trails the RUN transition by one cycle.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_state     <= ST_INIT;
            r_sweep     <= '0;
            r_init_done <= 1'b0;
            r_drop_seen <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_sweep <= r_sweep + INDEX_BITS'(1);
                if (r_sweep == c_SWEEP_LAST) begin
                    r_state <= ST_RUN;
                end
            end
            r_init_done <= (r_state == ST_RUN);
            if (bus.in_valid && !r_init_done) begin
                r_drop_seen <= 1'b1;
            end
        end
    end

    // P2 decision: the forwarded entry stands in for the stale memory read.
    always_comb begin
        w_entry         = r_p2_fwd ? r_p2_fwd_data : r_rd_data;
        w_hit           = w_entry[c_ENTRY_W-1] && (w_entry[KEY_SIZE-1:0] == r_p2_key);
        w_p2_we         = 1'b0;
        w_p2_new_status = c_SUSPECT;
        w_p2_status     = 2'b00;
        w_p2_hit_rep    = 1'b0;
        case (r_p2_op)
            c_SUSPECT: begin
                if (w_hit) begin
                    w_p2_status  = (w_entry[KEY_SIZE+1:KEY_SIZE] == c_ARREST) ? c_ARREST : c_SUSPECT;
                    w_p2_hit_rep = 1'b1;
                end else begin
                    w_p2_status = c_SUSPECT;
                    // Arrested flows are never evicted by a colliding key.
                    w_p2_we     = !(w_entry[c_ENTRY_W-1] &&
                                    (w_entry[KEY_SIZE+1:KEY_SIZE] == c_ARREST));
                end
            end
            c_ARREST: begin
                if (w_hit) begin
                    w_p2_we         = 1'b1;
                    w_p2_new_status = c_ARREST;
                    w_p2_status     = c_ARREST;
                    w_p2_hit_rep    = 1'b1;
                end
            end
            default: begin
                w_p2_status = 2'b00;
            end
        endcase
        w_p2_we    = w_p2_we && r_p2_valid;
        w_p2_wdata = {1'b1, w_p2_new_status, r_p2_key};
    end

    assign w_mem_we    = !eth_rst && ((r_state == ST_INIT) || w_p2_we);
    assign w_mem_waddr = (r_state == ST_INIT) ? r_sweep : r_p2_idx;
    assign w_mem_wdata = (r_state == ST_INIT) ? '0 : w_p2_wdata;

    always_ff @(posedge clk156) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        r_rd_data <= r_mem[r_p1_idx];
    end

    always_ff @(posedge clk156) begin
        r_p1_key      <= bus.in_key;
        r_p1_op       <= bus.in_flag[2:1];
        r_p1_idx      <= w_in_idx;
        r_p2_key      <= r_p1_key;
        r_p2_op       <= r_p1_op;
        r_p2_idx      <= r_p1_idx;
        r_p2_fwd      <= w_p2_we && (r_p2_idx == r_p1_idx);
        r_p2_fwd_data <= w_p2_wdata;
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_p1_valid   <= 1'b0;
            r_p2_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_flag   <= 4'b0000;
            r_arrest_cnt <= 6'd0;
        end else begin
            r_p1_valid  <= w_accept;
            r_p2_valid  <= r_p1_valid;
            r_out_valid <= r_p2_valid;
            r_out_flag  <= r_p2_valid ? {1'b0, w_p2_status, w_p2_hit_rep} : 4'b0000;
            if (r_p2_valid && (w_p2_status == c_ARREST)) begin
                r_arrest_cnt <= r_arrest_cnt + 6'd1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_flag  = r_out_flag;
    assign bus.init_done = r_init_done;
    assign bus.debug     = {r_init_done, r_drop_seen, r_arrest_cnt};

endmodule
`default_nettype wire
